// File: rtl/gate_bist.sv
// Built-in self test for a two-input gate block: walks {a1,a2} through 00..11 and flags per-output mismatches.
// Optional 16-bit response MISR on output sig when GATE_BIST_SIG_EN is defined.
module gate_bist #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a1,
  output logic        a2,
  input  logic [6:0]  y_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
`ifdef GATE_BIST_SIG_EN
  output logic [15:0] sig,
`endif
  output logic [6:0]  fail_mask
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [1:0]  vec_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [6:0]  fail_q;
  logic [6:0]  fail_d;
`ifdef GATE_BIST_SIG_EN
  logic [15:0] sig_q;
  logic [15:0] sig_d;
`endif

  // Golden response of the gate block; bit i is output y(i+1).
  function automatic logic [6:0] expected_resp(input logic [1:0] v);
    logic x1;
    logic x2;
    x1 = v[1];
    x2 = v[0];
    return {~(x1 ^ x2), x1 ^ x2, ~(x1 | x2), x1 | x2, ~(x1 & x2), x1 & x2, ~x1};
  endfunction

`ifdef GATE_BIST_SIG_EN
  // One MISR step, polynomial x^16+x^12+x^5+1, response folded into the low bits.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [6:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {9'b0, d};
  endfunction
`endif

  // Next values of the result registers for the current SAMPLE cycle.
  always_comb begin
    fail_d = fail_q | (y_in ^ expected_resp(vec_q));
`ifdef GATE_BIST_SIG_EN
    sig_d  = misr_step(sig_q, y_in);
`endif
  end

  // Sequencer FSM; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 7'd0;
`ifdef GATE_BIST_SIG_EN
      sig_q   <= 16'hFFFF;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SETTLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 7'd0;
`ifdef GATE_BIST_SIG_EN
            sig_q   <= 16'hFFFF;
`endif
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          fail_q <= fail_d;
          cnt_q  <= 4'd0;
`ifdef GATE_BIST_SIG_EN
          sig_q  <= sig_d;
`endif
          if (vec_q == 2'd3) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_d == 7'd0);
          end else begin
            state_q <= SETTLE;
            vec_q   <= vec_q + 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          vec_q   <= 2'd0;
          cnt_q   <= 4'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
          fail_q  <= 7'd0;
        end
      endcase
    end
  end

  assign a1        = vec_q[1];
  assign a2        = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;
`ifdef GATE_BIST_SIG_EN
  assign sig       = sig_q;
`endif

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: SETTLE_CYCLES=2 instance with fault injection, SETTLE_CYCLES=1 instance for held start.
module tb_gate_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  logic       a1_0, a2_0, a1_1, a2_1;
  logic [6:0] y0, y1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [6:0] mask0, mask1;
  logic [6:0] sa0, sa1;
`ifdef GATE_BIST_SIG_EN
  logic [15:0] sig0, sig1;
  logic [15:0] ref_good, ref_bad;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] gates(input logic x1, input logic x2);
    logic [6:0] r;
    r[0] = ~x1;
    r[1] = x1 & x2;
    r[2] = ~(x1 & x2);
    r[3] = x1 | x2;
    r[4] = ~(x1 | x2);
    r[5] = x1 ^ x2;
    r[6] = ~(x1 ^ x2);
    return r;
  endfunction

  assign y0 = (gates(a1_0, a2_0) & ~sa0) | sa1;
  assign y1 = gates(a1_1, a2_1);

  gate_bist #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .a1(a1_0), .a2(a2_0), .y_in(y0),
    .busy(busy0), .done(done0), .pass(pass0),
`ifdef GATE_BIST_SIG_EN
    .sig(sig0),
`endif
    .fail_mask(mask0)
  );

  gate_bist #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a1(a1_1), .a2(a2_1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1),
`ifdef GATE_BIST_SIG_EN
    .sig(sig1),
`endif
    .fail_mask(mask1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef GATE_BIST_SIG_EN
  function automatic logic [15:0] ref_misr(input logic [6:0] s0m, input logic [6:0] s1m);
    logic [15:0] s;
    logic [6:0]  d;
    logic [1:0]  v;
    s = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      d = (gates(v[1], v[0]) & ~s0m) | s1m;
      s = (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {9'd0, d};
    end
    return s;
  endfunction
`endif

  // One full run on the SETTLE_CYCLES=2 instance; optional start pulse while busy.
  task automatic run0(input string tag, input logic glitch, input logic [6:0] exp_mask, input logic exp_pass);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check({tag, "_start_busy"}, 16'(busy0), 16'd1);
    check({tag, "_start_done"}, 16'(done0), 16'd0);
    check({tag, "_start_mask"}, 16'(mask0), 16'd0);
    check({tag, "_start_pass"}, 16'(pass0), 16'd0);
    check({tag, "_vec0"}, 16'({a1_0, a2_0}), 16'd0);
    for (int i = 1; i <= 11; i++) begin
      start0 = glitch && (i == 4);
      tick();
      if (i == 3) check({tag, "_vec1"}, 16'({a1_0, a2_0}), 16'd1);
      if (i == 6) check({tag, "_vec2"}, 16'({a1_0, a2_0}), 16'd2);
      if (i == 9) check({tag, "_vec3"}, 16'({a1_0, a2_0}), 16'd3);
    end
    start0 = 1'b0;
    check({tag, "_k11_done"}, 16'(done0), 16'd0);
    check({tag, "_k11_busy"}, 16'(busy0), 16'd1);
    tick();
    check({tag, "_k12_done"}, 16'(done0), 16'd1);
    check({tag, "_k12_busy"}, 16'(busy0), 16'd0);
    check({tag, "_mask"}, 16'(mask0), 16'(exp_mask));
    check({tag, "_pass"}, 16'(pass0), 16'(exp_pass));
    check({tag, "_hold11"}, 16'({a1_0, a2_0}), 16'd3);
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    sa0    = 7'd0;
    sa1    = 7'd0;
    #3;
    check("rst_busy", 16'(busy0), 16'd0);
    check("rst_done", 16'(done0), 16'd0);
    check("rst_pass", 16'(pass0), 16'd0);
    check("rst_mask", 16'(mask0), 16'd0);
    check("rst_a", 16'({a1_0, a2_0}), 16'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy", 16'(busy0), 16'd0);
    check("idle_done", 16'(done0), 16'd0);

    // Correct gate model.
    run0("good", 1'b0, 7'b0000000, 1'b1);
`ifdef GATE_BIST_SIG_EN
    ref_good = ref_misr(7'd0, 7'd0);
    check("good_sig", sig0, ref_good);
`endif
    tick();
    check("done_hold", 16'(done0), 16'd1);
    check("pass_hold", 16'(pass0), 16'd1);

    // y3 (bit2) stuck at 0.
    sa0 = 7'b0000100;
    run0("sa0b2", 1'b0, 7'b0000100, 1'b0);
`ifdef GATE_BIST_SIG_EN
    ref_bad = ref_misr(7'b0000100, 7'd0);
    check("bad_sig", sig0, ref_bad);
    check("bad_sig_differs", 16'(sig0 != ref_good), 16'd1);
`endif

    // y2 (bit1) stuck at 1; start from DONE clears the previous mask.
    sa0 = 7'd0;
    sa1 = 7'b0000010;
    run0("sa1b1", 1'b0, 7'b0000010, 1'b0);

    // Back to the correct model, with a start pulse mid-run that must be ignored.
    sa1 = 7'd0;
    run0("regood", 1'b1, 7'b0000000, 1'b1);

    // SETTLE_CYCLES=1 instance, start held for three edges.
    start1 = 1'b1;
    tick();
    check("s1_start_busy", 16'(busy1), 16'd1);
    for (int i = 1; i <= 7; i++) begin
      start1 = (i <= 2);
      tick();
      if (i == 1) check("s1_vec0", 16'({a1_1, a2_1}), 16'd0);
      if (i == 3) check("s1_vec1", 16'({a1_1, a2_1}), 16'd1);
      if (i == 5) check("s1_vec2", 16'({a1_1, a2_1}), 16'd2);
      if (i == 7) check("s1_vec3", 16'({a1_1, a2_1}), 16'd3);
    end
    check("s1_k7_done", 16'(done1), 16'd0);
    tick();
    check("s1_k8_done", 16'(done1), 16'd1);
    check("s1_pass", 16'(pass1), 16'd1);
    check("s1_mask", 16'(mask1), 16'd0);
    for (int i = 0; i < 4; i++) tick();
    check("s1_one_run_busy", 16'(busy1), 16'd0);
    check("s1_one_run_done", 16'(done1), 16'd1);

    // Reset during SETTLE of vector 10 with a failing model.
    sa0 = 7'b0000100;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    check("mid_vec2", 16'({a1_0, a2_0}), 16'd2);
    check("mid_busy", 16'(busy0), 16'd1);
    check("mid_mask", 16'(mask0), 16'b0000100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 16'(busy0), 16'd0);
    check("arst_a", 16'({a1_0, a2_0}), 16'd0);
    check("arst_mask", 16'(mask0), 16'd0);
    check("arst_done", 16'(done0), 16'd0);
    check("arst_pass", 16'(pass0), 16'd0);
    check("arst_dut1_done", 16'(done1), 16'd0);
`ifdef GATE_BIST_SIG_EN
    check("arst_sig", sig0, 16'hFFFF);
`endif
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("post_busy", 16'(busy0), 16'd0);
    check("post_done", 16'(done0), 16'd0);
    check("post_a", 16'({a1_0, a2_0}), 16'd0);
    check("post_mask", 16'(mask0), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, which sets the number of clock cycles each input vector is held before its outputs are sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: run request, sampled on the rising edge of clk.
REQ-005 SHALL have port a1, output, 1 bit: stimulus to the gate block under test.
REQ-006 SHALL have port a2, output, 1 bit: stimulus to the gate block under test.
REQ-007 SHALL have port y_in, input, 7 bits: responses from the gate block under test; bit i carries output y(i+1), so bit 0 is NOT a1 and bit 6 is XNOR.
REQ-008 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-009 SHALL have port done, output, 1 bit: the run is complete and results are valid.
REQ-010 SHALL have port pass, output, 1 bit: high when done is high and fail_mask is zero.
REQ-011 SHALL have port fail_mask, output, 7 bits: sticky per-output mismatch flags, same bit order as y_in.

Function
REQ-012 SHALL implement an FSM with states IDLE, SETTLE, SAMPLE and DONE.
REQ-013 IDLE with start=1 at an edge: SHALL go to SETTLE, set vec=0, clear the settle counter and clear fail_mask; busy=1.
REQ-014 SHALL drive {a1,a2}=vec while busy; the vector order SHALL be 00, 01, 10, 11.
REQ-015 SETTLE: SHALL hold for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-016 SAMPLE, one cycle: SHALL compute the expected responses from vec, per output:
- bit0 = ~a1
- bit1 = a1&a2
- bit2 = ~(a1&a2)
- bit3 = a1|a2
- bit4 = ~(a1|a2)
- bit5 = a1^a2
- bit6 = ~(a1^a2)
REQ-017 SAMPLE: SHALL update fail_mask as fail_mask |= (y_in ^ expected).
REQ-018 SAMPLE with vec<3: SHALL increment vec and return to SETTLE with the counter cleared.
REQ-019 SAMPLE with vec=3: SHALL go to DONE.
REQ-020 DONE: busy=0, done=1; {a1,a2} SHALL hold 11; fail_mask and pass SHALL hold.
REQ-021 DONE with start=1: SHALL restart exactly as in REQ-013; done SHALL deassert on that edge.
REQ-022 start while busy SHALL be ignored, with no effect on vec, the counter or fail_mask.
REQ-023 Latency: if start is accepted at edge k, done SHALL rise at edge k+4*(SETTLE_CYCLES+1).
REQ-024 pass SHALL be 0 whenever done=0.
REQ-025 An X or Z on y_in is out of scope; y_in SHALL be treated as a known 2-state value.

Reset
REQ-026 rst_n=0 SHALL, asynchronously, force: state=IDLE, vec=0, counter=0, a1=0, a2=0, busy=0, done=0, pass=0, fail_mask=0.
REQ-027 Reset during any state, including mid-run, SHALL abort the run with no partial result retained; the block SHALL leave reset in IDLE and require a new start.

Configuration
REQ-028 Macro GATE_BIST_SIG_EN defined: SHALL add output port sig, 16 bits, a MISR.
- Polynomial x^16+x^12+x^5+1.
- Seeded to 16'hFFFF on reset and on each accepted start.
- Updated in SAMPLE only, with {9'b0,y_in} XORed into the shifted value.
- Stable in DONE.
REQ-029 Macro GATE_BIST_SIG_EN undefined: the sig port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Correct gate model on y_in, SETTLE_CYCLES=2, one start pulse -> done=1 at edge k+12, pass=1, fail_mask=7'b0000000.
REQ-031 y_in bit2 stuck at 0 -> fail_mask=7'b0000100, pass=0; y_in bit1 stuck at 1 -> fail_mask=7'b0000010.
REQ-032 SETTLE_CYCLES=1, start held high for 3 cycles -> exactly one run, done at edge k+8, vector sequence 00, 01, 10, 11 seen on {a1,a2}.
REQ-033 rst_n pulsed low during the SETTLE of vector 10 -> all outputs 0 immediately; after release, no activity until start.
REQ-034 Failing run, then start from DONE with the correct model -> fail_mask cleared on the start edge, final pass=1.
REQ-035 GATE_BIST_SIG_EN defined -> sig after a correct-model run equals the bench's reference MISR value, and differs for the stuck-bit2 model.
